// File: rtl/store_buffer.sv
// Store buffer between the core and data memory.
// Stores are queued in a small circular FIFO and drained to memory in program
// order through a valid/ready request port. Loads get combinational
// forwarding from the youngest pending store to the same word, otherwise the
// backing memory read data.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   stall,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [31:0]            mem_raddr,
  input  logic [31:0]            mem_rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [DEPTH-1:0] valid_reg, valid_next;

  // Entry payload: word address and data. Not reset; only the valid bits
  // decide whether an entry means anything.
  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic             full;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] match;
  logic [31:0]      fwd_data;

  // Acceptance uses the count before the edge, so a full buffer that drains
  // this cycle still refuses the incoming store.
  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  assign push  = cpu_we && !full;
  assign pop   = !empty && mem_req_ready;

  // Next-state for pointers, count and per-entry valid bits.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    valid_next  = valid_reg;
    if (push) begin
      wr_ptr_next            = wr_ptr_reg + PW'(1);
      valid_next[wr_ptr_reg] = 1'b1;
    end
    if (pop) begin
      rd_ptr_next            = rd_ptr_reg + PW'(1);
      valid_next[rd_ptr_reg] = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Control state register with asynchronous clear; pending stores are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= valid_next;
    end
  end

  // Capture the store payload; byte offset bits are dropped.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= cpu_addr[31:2];
      data_mem[wr_ptr_reg] <= cpu_wdata;
    end
  end

  // Per-entry word-address comparison against the load address.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (addr_mem[gi] == cpu_addr[31:2]);
    end
  endgenerate

  // Forwarding: walk from oldest to youngest so the youngest hit wins. The
  // entry draining this cycle is still valid here, so it still forwards.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_data = mem_rdata;
    idx      = rd_ptr_reg;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg + PW'(k);
      if (match[idx]) begin
        fwd_data = data_mem[idx];
      end
    end
  end

  assign cpu_rdata     = fwd_data;
  assign mem_raddr     = cpu_addr;
  assign stall         = cpu_we && full;
  assign mem_req_valid = !empty;
  assign mem_addr      = empty ? 32'h0 : {addr_mem[rd_ptr_reg], 2'b00};
  assign mem_wdata     = empty ? 32'h0 : data_mem[rd_ptr_reg];
  assign count         = count_reg;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios followed by random traffic.
// Accepted stores are pushed into an expected-request queue when issued; a
// monitor on the falling edge checks status, forwarding and every drained
// request against that queue.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        empty;
  logic [$clog2(DEPTH):0] count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .stall        (stall),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .empty        (empty),
    .count        (count)
  );

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
  } ent_t;

  ent_t exp_q[$];
  bit   pushed_now;
  int   n_total;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge. A store the
  // buffer will accept (fewer than DEPTH pending before the edge) becomes an
  // expected memory request.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic [31:0] mr);
    ent_t e;
    @(posedge clk);
    #1;
    cpu_we        = we;
    cpu_addr      = a;
    cpu_wdata     = d;
    mem_req_ready = rdy;
    mem_rdata     = mr;
    pushed_now    = 1'b0;
    if (we && exp_q.size() < DEPTH) begin
      e.wa = a[31:2];
      e.d  = d;
      exp_q.push_back(e);
      pushed_now = 1'b1;
    end
  endtask

  // Monitor: the store issued this cycle is not yet in the DUT, so only the
  // older queue entries count as committed.
  always @(negedge clk) begin
    int          committed;
    logic [31:0] fwd;
    ent_t        e;
    if (!reset) begin
      committed = exp_q.size() - (pushed_now ? 1 : 0);
      chk("count", 32'(count), 32'(committed));
      chk("empty", 32'(empty), 32'(committed == 0));
      chk("req_valid", 32'(mem_req_valid), 32'(committed != 0));
      chk("stall", 32'(stall), 32'(cpu_we && committed == DEPTH));
      chk("mem_raddr", mem_raddr, cpu_addr);
      fwd = mem_rdata;
      for (int i = 0; i < committed; i++) begin
        if (exp_q[i].wa == cpu_addr[31:2]) fwd = exp_q[i].d;
      end
      chk("cpu_rdata", cpu_rdata, fwd);
      if (committed != 0 && mem_req_ready) begin
        e = exp_q.pop_front();
        chk("mem_addr", mem_addr, {e.wa, 2'b00});
        chk("mem_wdata", mem_wdata, e.d);
        $display("drain addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
      end
    end
  end

  initial begin
    logic [31:0] a;
    n_total    = 0;
    n_pass     = 0;
    pushed_now = 1'b0;
    reset         = 1'b1;
    cpu_we        = 1'b0;
    cpu_addr      = 32'h0;
    cpu_wdata     = 32'h0;
    mem_req_ready = 1'b0;
    mem_rdata     = 32'h1234_5678;

    // Values held during reset.
    #3;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h1234_5678);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Single store, one cycle of latency, then drain.
    step(1'b1, 32'h64, 32'h7, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("single_valid", 32'(mem_req_valid), 32'h1);
    chk("single_addr", mem_addr, 32'h64);
    chk("single_data", mem_wdata, 32'h7);
    chk("single_count", 32'(count), 32'h1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1 chk("single_empty", 32'(empty), 32'h1);

    // Fill, stall on a fifth store, drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h60 + 32'(4 * i), 32'(i + 16), 1'b0, 32'h0);
    step(1'b1, 32'h70, 32'h55, 1'b0, 32'h0);
    #1;
    chk("fill_stall", 32'(stall), 32'h1);
    chk("fill_count", 32'(count), 32'h4);
    repeat (5) step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Forwarding from the youngest of two stores to one word.
    step(1'b1, 32'h60, 32'h1, 1'b0, 32'h0);
    step(1'b1, 32'h60, 32'h2, 1'b0, 32'h0);
    step(1'b0, 32'h62, 32'h0, 1'b0, 32'hDEAD);
    #1 chk("fwd_hit", cpu_rdata, 32'h2);
    step(1'b0, 32'h70, 32'h0, 1'b0, 32'hDEAD);
    #1 chk("fwd_miss", cpu_rdata, 32'hDEAD);
    repeat (3) step(1'b0, 32'h60, 32'h0, 1'b1, 32'hBEEF);

    // Full plus drain in the same cycle: the new store is refused.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + 32'(4 * i), 32'(i + 32), 1'b0, 32'h0);
    step(1'b1, 32'h80, 32'h9, 1'b1, 32'h0);
    #1 chk("fulldrain_stall", 32'(stall), 32'h1);
    step(1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
    #1 chk("fulldrain_count", 32'(count), 32'h3);
    repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Asynchronous reset with three stores pending.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(4 * i), 32'(i + 48), 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(mem_req_valid), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_count", 32'(count), 32'h0);
    exp_q.delete();
    pushed_now = 1'b0;
    cpu_we = 1'b1;
    #1 chk("arst_stall", 32'(stall), 32'h0);
    cpu_we = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    #1 chk("arst_no_stale", 32'(mem_req_valid), 32'h0);

    // Random traffic over a few words so forwarding and wrap get exercised.
    for (int n = 0; n < 400; n++) begin
      a = 32'h100 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      step($urandom_range(0, 99) < 60, a, $urandom, $urandom_range(0, 99) < 45, $urandom);
    end
    repeat (DEPTH + 2) step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    #1 chk("final_empty", 32'(empty), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
